// File: rtl/wb_cfg_pkg.sv
// Shared definitions for the Wishbone configuration-chain loader:
// register map, STATUS/CTRL bit positions and the shifter state encoding.
package wb_cfg_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_DATA   = 4'h8;
    localparam logic [3:0] OFF_COUNT  = 4'hC;

    localparam int CTRL_CLR   = 8;
    localparam int CTRL_ABORT = 9;

    localparam int ST_BUSY    = 8;
    localparam int ST_FULL    = 9;
    localparam int ST_OVF     = 10;
    localparam int ST_SEL_ERR = 11;
    localparam int ST_LEVEL   = 12;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_e;

endpackage

// File: rtl/wb_cfg_fifo.sv
// Synchronous 32-bit word FIFO, first-word fall-through, with occupancy
// output and a single-cycle flush.
module wb_cfg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              din,
    output logic [31:0]              dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone slave that buffers bitstream words and serialises them,
// SHIFT_W bits per cycle, into one of NUM_CH configuration chains.
module wb_cfg_loader
    import wb_cfg_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          SHIFT_W     = 1,
    parameter int          BITS_PER_CH = 4096,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_CH*SHIFT_W-1:0] cfg_shift_out,
    output logic [NUM_CH-1:0]         cfg_cen,
    output logic [NUM_CH-1:0]         cfg_set_out
);
    localparam int CW    = $clog2(BITS_PER_CH + 1);
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int BEATS = 32 / SHIFT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    shift_state_e              state, state_nxt;
    logic [31:0]               shift_reg;
    logic [BW-1:0]             beat;
    logic [NUM_CH-1:0][CW-1:0] cnt;
    logic [2:0]                sel;
    logic                      ovf, sel_err;

    logic [31:0]   fifo_dout;
    logic          fifo_empty, fifo_full;
    logic [LW-1:0] fifo_level;
    logic          pop, load, flush, set_done;

    logic [SW-1:0] sel_idx, clr_idx;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    off;
    logic [2:0]    new_sel;
    logic          busy, req, wr_ok, data_wr, ctrl_wr, data_drop, push, stall;
    logic          do_ack, abort, clr, sel_bad, sel_take;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign sel_idx = sel[SW-1:0];
    assign busy    = (state != IDLE);
    assign cnt_inc = cnt[sel_idx] + CW'(SHIFT_W);
    assign off     = wbs_adr_i[3:0];
    assign new_sel = wbs_dat_i[2:0];

    // Request is taken once per transfer; ack gates off the second look.
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_ok     = req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign data_wr   = wr_ok & (off == OFF_DATA);
    assign ctrl_wr   = wr_ok & (off == OFF_CTRL);
    assign data_drop = data_wr & cfg_set_out[sel_idx];
    assign push      = data_wr & ~cfg_set_out[sel_idx] & ~fifo_full;
    assign stall     = data_wr & ~cfg_set_out[sel_idx] & fifo_full;
    assign do_ack    = req & ~stall;
    assign abort     = ctrl_wr & wbs_dat_i[CTRL_ABORT];
    assign clr       = ctrl_wr & wbs_dat_i[CTRL_CLR];
    assign sel_bad   = ctrl_wr & (new_sel != sel) &
                       (busy | ~fifo_empty | ({29'd0, new_sel} >= 32'(NUM_CH)));
    assign sel_take  = ctrl_wr & (new_sel != sel) & ~sel_bad;
    assign clr_idx   = sel_take ? new_sel[SW-1:0] : sel_idx;
    assign unused_ok = &{1'b0, wbs_dat_i[31:10], wbs_dat_i[7:3]};

    wb_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (wbs_dat_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        flush     = 1'b0;
        set_done  = 1'b0;
        case (state)
            IDLE: if (!fifo_empty && !cfg_set_out[sel_idx]) begin
                pop       = 1'b1;
                load      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: if (cnt_inc == CW'(BITS_PER_CH)) begin
                set_done  = 1'b1;
                state_nxt = DONE;
            end else if (beat == BW'(BEATS - 1)) begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                flush     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A chain that just completed still reports done; everything queued is dropped.
        if (abort) begin
            pop       = 1'b0;
            load      = 1'b0;
            flush     = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata[2:0] = sel;
            OFF_STATUS: begin
                rdata[NUM_CH-1:0]        = cfg_set_out;
                rdata[ST_BUSY]           = busy;
                rdata[ST_FULL]           = fifo_full;
                rdata[ST_OVF]            = ovf;
                rdata[ST_SEL_ERR]        = sel_err;
                rdata[ST_LEVEL +: 4]     = 4'(fifo_level);
            end
            OFF_COUNT:  rdata[CW-1:0] = cnt[sel_idx];
            default:    ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            shift_reg   <= '0;
            beat        <= '0;
            cnt         <= '0;
            cfg_set_out <= '0;
            sel         <= '0;
            ovf         <= 1'b0;
            sel_err     <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
        end else begin
            state     <= state_nxt;
            wbs_ack_o <= do_ack;
            wbs_dat_o <= (do_ack && !wbs_we_i) ? rdata : '0;
            if (state == SHIFT) begin
                shift_reg    <= shift_reg >> SHIFT_W;
                beat         <= beat + 1'b1;
                cnt[sel_idx] <= cnt_inc;
            end
            if (load) begin
                shift_reg <= fifo_dout;
                beat      <= '0;
            end
            if (set_done)  cfg_set_out[sel_idx] <= 1'b1;
            if (data_drop) ovf <= 1'b1;
            if (sel_take)  sel <= new_sel;
            if (clr) begin
                cfg_set_out[clr_idx] <= 1'b0;
                cnt[clr_idx]         <= '0;
                ovf                  <= 1'b0;
                sel_err              <= 1'b0;
            end
            if (sel_bad) sel_err <= 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign cfg_cen[c] = (state == SHIFT) && (sel_idx == SW'(c));
        assign cfg_shift_out[c*SHIFT_W +: SHIFT_W] = cfg_cen[c] ? shift_reg[SHIFT_W-1:0] : '0;
    end

endmodule
